// File: rtl/tx_nrzi_serializer.sv
// USB transmit serializer: takes parallel words over a valid/ready handshake,
// shifts them out one bit per strobe, inserts stuff zeros after a run of ones
// and NRZI-encodes the resulting bit stream onto the line.
module tx_nrzi_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int STUFF_RUN  = 6,
  parameter int SHIFT_MSB  = 0
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [DATA_WIDTH-1:0] parallel_in,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic                  bit_strobe,
  input  logic                  stuff_enable,
  input  logic                  nrzi_enable,
  output logic                  serial_out,
  output logic                  line_out,
  output logic                  stuffed,
  output logic                  word_done,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam int OW = $clog2(STUFF_RUN + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic [OW-1:0] RUN_MAX  = OW'(STUFF_RUN);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    TAIL_STUFF
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [OW-1:0]         ones_cnt_q, ones_cnt_d;
  logic                  serial_q, serial_d;
  logic                  line_q, line_d;
  logic                  stuffed_q, stuffed_d;
  logic                  word_done_q, word_done_d;

  logic                  lastBit;
  logic                  stuffNow;
  logic                  accept;
  logic                  dataBit;
  logic [DATA_WIDTH-1:0] srShifted;
  logic [OW-1:0]         onesNext;
  logic                  emit;
  logic                  emitBit;

  // Handshake and data-path helpers: the next word may be taken either from
  // IDLE or on the strobe that emits the final data bit, so words abut.
  always_comb begin
    lastBit    = (bit_cnt_q == LAST_BIT);
    stuffNow   = stuff_enable && (ones_cnt_q == RUN_MAX);
    load_ready = (state_q == IDLE) ||
                 ((state_q == SHIFT) && bit_strobe && lastBit && !stuffNow);
    accept     = load_valid && load_ready;
    if (SHIFT_MSB != 0) begin
      dataBit   = sr_q[DATA_WIDTH-1];
      srShifted = {sr_q[DATA_WIDTH-2:0], 1'b1};
    end else begin
      dataBit   = sr_q[0];
      srShifted = {1'b1, sr_q[DATA_WIDTH-1:1]};
    end
  end

  // Next-state logic: picks stuff or data bit per strobe, tracks the ones run
  // across word boundaries, and encodes each emitted bit onto the line.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    ones_cnt_d  = ones_cnt_q;
    serial_d    = serial_q;
    line_d      = line_q;
    stuffed_d   = stuffed_q;
    word_done_d = 1'b0;
    onesNext    = ones_cnt_q;
    emit        = 1'b0;
    emitBit     = 1'b1;

    case (state_q)
      IDLE: begin
        if (accept) begin
          sr_d      = parallel_in;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_strobe) begin
          emit = 1'b1;
          if (stuffNow) begin
            emitBit    = 1'b0;
            stuffed_d  = 1'b1;
            ones_cnt_d = '0;
          end else begin
            emitBit   = dataBit;
            stuffed_d = 1'b0;
            if (!dataBit) begin
              onesNext = '0;
            end else if (ones_cnt_q != RUN_MAX) begin
              onesNext = ones_cnt_q + 1'b1;
            end
            ones_cnt_d = onesNext;
            sr_d       = srShifted;
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (lastBit) begin
              word_done_d = 1'b1;
              bit_cnt_d   = '0;
              if (accept) begin
                sr_d = parallel_in;
              end else if (stuff_enable && (onesNext == RUN_MAX)) begin
                state_d = TAIL_STUFF;
              end else begin
                state_d    = IDLE;
                ones_cnt_d = '0;
              end
            end
          end
        end
      end
      TAIL_STUFF: begin
        if (bit_strobe) begin
          emit       = 1'b1;
          emitBit    = 1'b0;
          stuffed_d  = 1'b1;
          ones_cnt_d = '0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        ones_cnt_d = '0;
      end
    endcase

    if (emit) begin
      serial_d = emitBit;
      if (nrzi_enable) begin
        line_d = emitBit ? line_q : ~line_q;
      end else begin
        line_d = emitBit;
      end
    end
  end

  // State and output registers; reset parks the line at J with an all-ones
  // shift register so an aborted word leaves nothing behind.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      sr_q        <= '1;
      bit_cnt_q   <= '0;
      ones_cnt_q  <= '0;
      serial_q    <= 1'b1;
      line_q      <= 1'b1;
      stuffed_q   <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      ones_cnt_q  <= ones_cnt_d;
      serial_q    <= serial_d;
      line_q      <= line_d;
      stuffed_q   <= stuffed_d;
      word_done_q <= word_done_d;
    end
  end

  assign serial_out = serial_q;
  assign line_out   = line_q;
  assign stuffed    = stuffed_q;
  assign word_done  = word_done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_tx_nrzi_serializer.sv
// Testbench for tx_nrzi_serializer: a table of per-clock vectors drives an
// LSB-first instance, and a hand-written sequence exercises an MSB-first
// instance with NRZI off and a mid-word reset.
module tb_tx_nrzi_serializer;

  typedef struct {
    logic       ld;
    logic [7:0] data;
    logic       stb;
    logic       se;
    logic       rdy;
    logic       s;
    logic       l;
    logic       st;
    logic       d;
    logic       b;
  } vec_t;

  typedef struct {
    logic s;
    logic l;
    logic st;
    logic d;
    logic b;
  } exp_t;

  logic       clk;
  logic       nRst;
  logic [7:0] parallelIn;
  logic       loadValid;
  logic       bitStrobe;
  logic       stuffEnable;
  logic       nrziEnable;
  logic [1:0] loadReady;
  logic [1:0] serialOut;
  logic [1:0] lineOut;
  logic [1:0] stuffedOut;
  logic [1:0] wordDone;
  logic [1:0] busyOut;

  int   compared;
  int   mismatched;
  vec_t rows[$];
  exp_t sbQ[$];

  tx_nrzi_serializer #(.DATA_WIDTH(8), .STUFF_RUN(6), .SHIFT_MSB(0)) dutLsb (
    .clk(clk), .n_rst(nRst), .parallel_in(parallelIn), .load_valid(loadValid),
    .load_ready(loadReady[0]), .bit_strobe(bitStrobe), .stuff_enable(stuffEnable),
    .nrzi_enable(nrziEnable), .serial_out(serialOut[0]), .line_out(lineOut[0]),
    .stuffed(stuffedOut[0]), .word_done(wordDone[0]), .busy(busyOut[0])
  );

  tx_nrzi_serializer #(.DATA_WIDTH(8), .STUFF_RUN(6), .SHIFT_MSB(1)) dutMsb (
    .clk(clk), .n_rst(nRst), .parallel_in(parallelIn), .load_valid(loadValid),
    .load_ready(loadReady[1]), .bit_strobe(bitStrobe), .stuff_enable(stuffEnable),
    .nrzi_enable(nrziEnable), .serial_out(serialOut[1]), .line_out(lineOut[1]),
    .stuffed(stuffedOut[1]), .word_done(wordDone[1]), .busy(busyOut[1])
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic compareBit(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input int d, input string tag);
    exp_t e;
    if (sbQ.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: scoreboard empty", tag);
    end else begin
      e = sbQ.pop_front();
      compareBit({tag, ".serial"}, serialOut[d], e.s);
      compareBit({tag, ".line"}, lineOut[d], e.l);
      compareBit({tag, ".stuffed"}, stuffedOut[d], e.st);
      compareBit({tag, ".word_done"}, wordDone[d], e.d);
      compareBit({tag, ".busy"}, busyOut[d], e.b);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("row%0d", idx);
    @(negedge clk);
    stuffEnable = v.se;
    loadValid   = v.ld;
    parallelIn  = v.data;
    bitStrobe   = v.stb;
    #1;
    compareBit({tag, ".load_ready"}, loadReady[0], v.rdy);
    sbQ.push_back('{v.s, v.l, v.st, v.d, v.b});
    @(posedge clk);
    #1;
    loadValid = 1'b0;
    bitStrobe = 1'b0;
    @(negedge clk);
    checkOutput(0, tag);
    repeat (2) @(posedge clk);
  endtask

  task automatic addRow(input logic ld, input logic [7:0] data, input logic stb,
                        input logic se, input logic rdy, input logic s, input logic l,
                        input logic st, input logic d, input logic b);
    rows.push_back('{ld, data, stb, se, rdy, s, l, st, d, b});
  endtask

  task automatic strobeMsb(input logic s, input logic l, input logic b, input string tag);
    @(negedge clk);
    bitStrobe = 1'b1;
    sbQ.push_back('{s, l, 1'b0, 1'b0, b});
    @(posedge clk);
    #1;
    bitStrobe = 1'b0;
    @(negedge clk);
    checkOutput(1, tag);
    @(posedge clk);
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    nRst        = 1'b0;
    parallelIn  = 8'h00;
    loadValid   = 1'b0;
    bitStrobe   = 1'b0;
    stuffEnable = 1'b1;
    nrziEnable  = 1'b1;

    // Idle strobes leave outputs at reset values.
    addRow(0, 8'h00, 1, 1, 1, 1, 1, 0, 0, 0);
    addRow(0, 8'h00, 1, 1, 1, 1, 1, 0, 0, 0);
    // 8'hA5 LSB-first with NRZI.
    addRow(1, 8'hA5, 1, 1, 1, 1, 1, 0, 0, 1);
    addRow(0, 8'h00, 1, 1, 0, 1, 1, 0, 0, 1);
    addRow(0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 1);
    addRow(0, 8'h00, 1, 1, 0, 1, 0, 0, 0, 1);
    addRow(0, 8'h00, 1, 1, 0, 0, 1, 0, 0, 1);
    addRow(0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 1);
    addRow(0, 8'h00, 1, 1, 0, 1, 0, 0, 0, 1);
    addRow(0, 8'h00, 1, 1, 0, 0, 1, 0, 0, 1);
    addRow(0, 8'h00, 1, 1, 1, 1, 1, 0, 1, 0);
    addRow(0, 8'h00, 1, 1, 1, 1, 1, 0, 0, 0);
    // 8'hFF alone: six ones, stuff, two ones, no tail stuff.
    addRow(1, 8'hFF, 1, 1, 1, 1, 1, 0, 0, 1);
    for (int i = 0; i < 6; i++) addRow(0, 8'h00, 1, 1, 0, 1, 1, 0, 0, 1);
    addRow(0, 8'h00, 1, 1, 0, 0, 0, 1, 0, 1);
    addRow(0, 8'h00, 1, 1, 0, 1, 0, 0, 0, 1);
    addRow(0, 8'h00, 1, 1, 1, 1, 0, 0, 1, 0);
    // 8'hFF then 8'h3F back-to-back; run of two carries into the next word.
    addRow(1, 8'hFF, 1, 1, 1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) addRow(0, 8'h00, 1, 1, 0, 1, 0, 0, 0, 1);
    addRow(0, 8'h00, 1, 1, 0, 0, 1, 1, 0, 1);
    addRow(0, 8'h00, 1, 1, 0, 1, 1, 0, 0, 1);
    addRow(1, 8'h3F, 1, 1, 1, 1, 1, 0, 1, 1);
    for (int i = 0; i < 4; i++) addRow(0, 8'h00, 1, 1, 0, 1, 1, 0, 0, 1);
    addRow(0, 8'h00, 1, 1, 0, 0, 0, 1, 0, 1);
    addRow(0, 8'h00, 1, 1, 0, 1, 0, 0, 0, 1);
    addRow(0, 8'h00, 1, 1, 0, 1, 0, 0, 0, 1);
    addRow(0, 8'h00, 1, 1, 0, 0, 1, 0, 0, 1);
    addRow(0, 8'h00, 1, 1, 1, 0, 0, 0, 1, 0);
    // 8'hFC ends on six ones: tail stuff, load refused meanwhile.
    addRow(1, 8'hFC, 1, 1, 1, 0, 0, 0, 0, 1);
    addRow(0, 8'h00, 1, 1, 0, 0, 1, 0, 0, 1);
    addRow(0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) addRow(0, 8'h00, 1, 1, 0, 1, 0, 0, 0, 1);
    addRow(0, 8'h00, 1, 1, 1, 1, 0, 0, 1, 1);
    addRow(1, 8'h00, 0, 1, 0, 1, 0, 0, 0, 1);
    addRow(0, 8'h00, 1, 1, 0, 0, 1, 1, 0, 0);
    addRow(0, 8'h00, 1, 1, 1, 0, 1, 1, 0, 0);
    // Stuffing off: 8'hFF goes out as eight ones, no stuff, no tail.
    addRow(1, 8'hFF, 1, 0, 1, 0, 1, 1, 0, 1);
    for (int i = 0; i < 7; i++) addRow(0, 8'h00, 1, 0, 0, 1, 1, 0, 0, 1);
    addRow(0, 8'h00, 1, 0, 1, 1, 1, 0, 1, 0);
    // Stuffing back on: the run restarts from zero after IDLE.
    addRow(1, 8'hFF, 1, 1, 1, 1, 1, 0, 0, 1);
    for (int i = 0; i < 6; i++) addRow(0, 8'h00, 1, 1, 0, 1, 1, 0, 0, 1);
    addRow(0, 8'h00, 1, 1, 0, 0, 0, 1, 0, 1);
    addRow(0, 8'h00, 1, 1, 0, 1, 0, 0, 0, 1);
    addRow(0, 8'h00, 1, 1, 1, 1, 0, 0, 1, 0);

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      sbQ.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      checkOutput(d, $sformatf("reset%0d", d));
      compareBit($sformatf("reset%0d.load_ready", d), loadReady[d], 1'b1);
    end
    @(negedge clk);
    nRst = 1'b1;

    $display("[TB] applying %0d table rows", rows.size());
    for (int i = 0; i < rows.size(); i++) begin
      applyStimulus(rows[i], i);
    end

    // MSB-first, NRZI off, 8'h80 with reset after the third bit.
    $display("[TB] MSB-first sequence with mid-word reset");
    @(negedge clk);
    nrziEnable  = 1'b0;
    stuffEnable = 1'b1;
    nRst        = 1'b0;
    @(negedge clk);
    nRst        = 1'b1;
    parallelIn  = 8'h80;
    loadValid   = 1'b1;
    @(posedge clk);
    #1;
    loadValid = 1'b0;
    strobeMsb(1'b1, 1'b1, 1'b1, "msb.bit1");
    strobeMsb(1'b0, 1'b0, 1'b1, "msb.bit2");
    strobeMsb(1'b0, 1'b0, 1'b1, "msb.bit3");
    #2;
    nRst = 1'b0;
    #1;
    sbQ.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    checkOutput(1, "msb.abort");
    compareBit("msb.abort.load_ready", loadReady[1], 1'b1);
    @(negedge clk);
    nRst = 1'b1;
    strobeMsb(1'b1, 1'b1, 1'b0, "msb.after1");
    strobeMsb(1'b1, 1'b1, 1'b0, "msb.after2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tx_nrzi_serializer.md
# tx_nrzi_serializer

Parametrised transmit serializer for the USB TX path. It accepts parallel words over a valid/ready handshake and shifts them out one bit per `bit_strobe`, LSB- or MSB-first. It inserts USB bit-stuff zeros after a programmable run of ones and NRZI-encodes the line. It sits between the TX packet controller, which supplies bytes, and the TX line driver, which consumes `line_out`.

## Interface
- `DATA_WIDTH`, 8: word width in bits; must be ≥ 2.
- `STUFF_RUN`, 6: consecutive transmitted data ones after which a stuff zero is inserted; must be ≥ 1.
- `SHIFT_MSB`, 0: 0 = LSB first, 1 = MSB first.

Ports:
- `clk`  in  1: system clock, rising edge.
- `n_rst`  in  1: asynchronous, active-low reset.
- `parallel_in`  in  DATA_WIDTH: word to transmit.
- `load_valid`  in  1: producer offers `parallel_in`.
- `load_ready`  out  1: combinational; a word is accepted on a clock edge where `load_valid & load_ready`.
- `bit_strobe`  in  1: one-cycle pulse, once per bit period.
- `stuff_enable`  in  1: enables bit stuffing.
- `nrzi_enable`  in  1: 1 = NRZI-encode; 0 = `line_out` follows the emitted bit.
- `serial_out`  out  1: registered; last emitted bit before encoding.
- `line_out`  out  1: registered; encoded line level.
- `stuffed`  out  1: registered; high while `serial_out` holds a stuff bit.
- `word_done`  out  1: one-clock pulse registered on emission of a word's last data bit.
- `busy`  out  1: state ≠ IDLE.

## Operation
- Internal state:
  - `sr[DATA_WIDTH-1:0]`
  - `bit_cnt`, width `$clog2(DATA_WIDTH)`
  - `ones_cnt`, width `$clog2(STUFF_RUN+1)`
  - FSM with states IDLE, SHIFT and TAIL_STUFF.
- Shift direction:
  - LSB-first: emit `sr[0]`, shift right and fill with 1.
  - MSB-first: emit `sr[MSB]`, shift left and fill with 1.
- `load_ready` is high in either of two cases:
  - the FSM is in IDLE;
  - the FSM is in SHIFT, `bit_strobe` is high, `bit_cnt == DATA_WIDTH-1` and this strobe emits data, not stuff.
- Accepting a word:
  - `sr` ← `parallel_in` and `bit_cnt` ← 0.
  - The FSM moves to or stays in SHIFT.
  - In IDLE, a strobe arriving in the same cycle as a load is ignored; the first bit goes out on the next strobe.
- SHIFT, on each strobe, chooses a stuff bit or a data bit.
- Stuff bit, when `stuff_enable` is high and `ones_cnt == STUFF_RUN`:
  - Emit 0, set `stuffed` = 1 and clear `ones_cnt`.
  - `sr` and `bit_cnt` do not change.
- Data bit, otherwise:
  - Emit the data bit and set `stuffed` = 0.
  - `ones_cnt` increments on a 1 and clears on a 0. It saturates at `STUFF_RUN` when `stuff_enable` is 0.
  - Shift `sr` and increment `bit_cnt`.
- Last data bit (`bit_cnt == DATA_WIDTH-1`): pulse `word_done`, then:
  - if a new word is accepted on this strobe, stay in SHIFT and keep `ones_cnt`, so runs span word boundaries;
  - else if `stuff_enable` is high and `ones_cnt` is now `STUFF_RUN`, go to TAIL_STUFF;
  - else go to IDLE.
- TAIL_STUFF: on the next strobe emit a stuff 0, set `stuffed` = 1 and go to IDLE. `load_ready` is 0 in this state.
- Entering IDLE clears `ones_cnt`. In IDLE, strobes are ignored and all outputs hold.
- Encoding, on every emitted bit `b`:
  - with `nrzi_enable` = 1: `line_out` toggles if `b` = 0 and holds if `b` = 1;
  - with `nrzi_enable` = 0: `line_out` ← `b`.

## Timing
- Reset values:
  - `serial_out` = 1, `line_out` = 1 (J/idle), `stuffed` = 0, `word_done` = 0, `busy` = 0;
  - `load_ready` = 1, FSM in IDLE, `sr` all ones, both counters 0.
- Reset asserted mid-word aborts the word immediately; no further bits are emitted and there is no tail stuff.
- Each emitted bit appears on `serial_out` / `line_out` one clock after its strobe edge.
- `word_done` pulses high for one clock, in the same cycle that the last data bit appears on `serial_out`.
- Back-to-back words leave no idle bit period between them.
- Bit periods per word:
  - `DATA_WIDTH` plus the number of stuffs, plus 1 when a tail stuff is needed;
  - the minimum strobe spacing is 1 clock.

## Test plan
1. Reset → `line_out`=1, `serial_out`=1, `busy`=0, `load_ready`=1; strobes with no load leave the outputs unchanged.
2. Load 8'hA5, LSB-first, NRZI and stuffing on, strobe every 4 clocks:
   - `serial_out` = 1,0,1,0,0,1,0,1;
   - `line_out` = 1,0,0,1,0,0,1,1;
   - `word_done` on the 8th bit, then IDLE.
3. Load 8'hFF, `STUFF_RUN`=6, no follow-on word:
   - bits 1×6, 0 (`stuffed`=1), 1,1, giving 9 strobes;
   - `word_done` on the 9th; then IDLE with no tail stuff, because the run is 2.
4. Load 8'hFF, then 8'h3F back-to-back:
   - `load_ready` is high on the 8th-data strobe of the first word;
   - second word emits 1,1,1,1, stuff 0, 1,1,0,0, because the run is carried across the boundary.
5. Load 8'hFC, no follow-on word:
   - bits 0,0,1,1,1,1,1,1, with `word_done` on the last;
   - TAIL_STUFF emits a 0 on the next strobe, `stuffed`=1, `load_ready`=0 meanwhile;
   - then IDLE.
6. With `nrzi_enable`=0 and `SHIFT_MSB`=1, load 8'h80 → `line_out` = 1,0,0,0,0,0,0,0. Assert `n_rst` after the 3rd bit → all outputs return to reset values at once.
